// File: rtl/sseg_pkg.sv
// Shared constants and types for the multiplexed 7-segment bus.
// Segment patterns are a..g, MSB = a, active-low.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_POS0 = 4'b0111;
  localparam logic [3:0] AN_POS1 = 4'b1011;
  localparam logic [3:0] AN_POS2 = 4'b1101;
  localparam logic [3:0] AN_POS3 = 4'b1110;
  localparam logic [3:0] AN_NONE = 4'b1111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD   = 4'hE;

  typedef enum logic {
    IDLE,
    SCAN
  } scan_state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       dp;
    logic       invalid;
  } digit_t;

  // Returns {one_hot_valid, position}; anything but a single low anode is invalid.
  function automatic logic [2:0] an_decode(input logic [3:0] an);
    logic [2:0] r;
    case (an)
      AN_POS0: r = 3'b100;
      AN_POS1: r = 3'b101;
      AN_POS2: r = 3'b110;
      AN_POS3: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sseg_seg2bcd.sv
// Combinational 7-segment pattern to BCD decoder.
// Blank decodes to CODE_BLANK; unknown patterns to CODE_BAD with invalid set.
module sseg_seg2bcd
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = CODE_BAD;
    invalid = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/disp_scan_capture.sv
// Captures frames from the scanned 4-digit 7-segment bus: input register,
// stability filter, segment decode, frame sequencer and staleness timeout.
module disp_scan_capture
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] DISP,
  output logic [15:0] DIGITS,
  output logic [3:0]  DP,
  output logic [3:0]  INVALID,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        sync_err,
  output logic        timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]    STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [11:0]   din_q;
  logic [7:0]    stab_cnt;
  logic [2:0]    an_info;
  logic          accept;
  logic [3:0]    dec_code;
  logic          dec_invalid;

  logic          acc_q;
  logic [1:0]    acc_pos;
  digit_t        acc_dig;

  scan_state_t   state, state_n;
  logic [1:0]    exp, exp_n;
  digit_t [3:0]  shadow, shadow_n;
  logic          shadow_we;
  logic          commit;
  logic          seq_err;
  logic          to_hit;
  logic [TW-1:0] to_cnt;

  // Comparing DISP against din_q at the edge is the same as comparing the
  // new din_q against its previous value, without a second copy of the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q    <= '1;
      stab_cnt <= '0;
    end else begin
      din_q <= DISP;
      if (DISP != din_q)
        stab_cnt <= '0;
      else if (stab_cnt != '1)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  assign an_info = an_decode(din_q[11:8]);
  assign accept  = (stab_cnt == STAB_LAST) && an_info[2];

  sseg_seg2bcd u_seg2bcd (
    .seg     (din_q[7:1]),
    .code    (dec_code),
    .invalid (dec_invalid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= 1'b0;
      acc_pos <= '0;
      acc_dig <= '0;
    end else begin
      acc_q           <= accept;
      acc_pos         <= an_info[1:0];
      acc_dig.code    <= dec_code;
      acc_dig.dp      <= ~din_q[0];
      acc_dig.invalid <= dec_invalid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      exp   <= '0;
    end else begin
      state <= state_n;
      exp   <= exp_n;
    end
  end

  always_comb begin
    state_n   = state;
    exp_n     = exp;
    shadow_we = 1'b0;
    commit    = 1'b0;
    seq_err   = 1'b0;
    if (acc_q) begin
      case (state)
        IDLE: begin
          if (acc_pos == 2'd0) begin
            shadow_we = 1'b1;
            exp_n     = 2'd1;
            state_n   = SCAN;
          end
        end
        SCAN: begin
          if (acc_pos == exp) begin
            shadow_we = 1'b1;
            if (exp == 2'd3) begin
              commit  = 1'b1;
              state_n = IDLE;
            end else begin
              exp_n = exp + 2'd1;
            end
          end else if (acc_pos == exp - 2'd1) begin
            shadow_we = 1'b1;
          end else if (acc_pos == 2'd0) begin
            shadow_we = 1'b1;
            exp_n     = 2'd1;
            seq_err   = 1'b1;
          end else begin
            seq_err = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // A commit on the same cycle as expiry keeps the frame alive.
    to_hit = (to_cnt == TO_LAST) && !commit;
    if (to_hit)
      state_n = IDLE;
  end

  // The committing digit is written in the same edge, so outputs copy the
  // post-write shadow image.
  always_comb begin
    shadow_n = shadow;
    if (shadow_we)
      shadow_n[acc_pos] = acc_dig;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow      <= '0;
      to_cnt      <= '0;
      DIGITS      <= 16'hFFFF;
      DP          <= '0;
      INVALID     <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      shadow     <= shadow_n;
      frame_done <= commit;
      sync_err   <= seq_err;
      timeout    <= to_hit;
      if (commit || to_hit)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TW'(1);
      if (commit) begin
        DIGITS      <= {shadow_n[0].code, shadow_n[1].code,
                        shadow_n[2].code, shadow_n[3].code};
        DP          <= {shadow_n[0].dp, shadow_n[1].dp,
                        shadow_n[2].dp, shadow_n[3].dp};
        INVALID     <= {shadow_n[0].invalid, shadow_n[1].invalid,
                        shadow_n[2].invalid, shadow_n[3].invalid};
        frame_valid <= 1'b1;
      end else if (to_hit) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_capture.sv
// Directed bench for disp_scan_capture: one instance with the default timeout
// and one with a 64-cycle timeout, both fed the same scanned bus.
module tb_disp_scan_capture;
  import sseg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] DISP = 12'hFFF;

  logic [15:0] digits, digits_to;
  logic [3:0]  dp, dp_to, invalid, invalid_to;
  logic        frame_valid, frame_valid_to;
  logic        frame_done, frame_done_to;
  logic        sync_err, sync_err_to;
  logic        timeout, timeout_to;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned fd_cnt = 0;
  int unsigned se_cnt = 0;
  int unsigned fd0, se0, k;
  logic        seen;

  always #5 clk = ~clk;

  disp_scan_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(65535)) dut (
    .clk(clk), .rst_n(rst_n), .DISP(DISP),
    .DIGITS(digits), .DP(dp), .INVALID(invalid),
    .frame_valid(frame_valid), .frame_done(frame_done),
    .sync_err(sync_err), .timeout(timeout)
  );

  disp_scan_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut_to (
    .clk(clk), .rst_n(rst_n), .DISP(DISP),
    .DIGITS(digits_to), .DP(dp_to), .INVALID(invalid_to),
    .frame_valid(frame_valid_to), .frame_done(frame_done_to),
    .sync_err(sync_err_to), .timeout(timeout_to)
  );

  // Pulses are sampled on the edge after they appear, so each is counted once.
  always @(posedge clk) begin
    if (frame_done) fd_cnt++;
    if (sync_err)   se_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg,
                       input logic dp_lit, input int unsigned n);
    DISP = {an, seg, ~dp_lit};
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    DISP  = 12'hFFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_digits", digits, 16'hFFFF);
    chk("rst_dp", {12'h0, dp}, 16'h0);
    chk("rst_invalid", {12'h0, invalid}, 16'h0);
    chk("rst_fv", {15'h0, frame_valid}, 16'h0);
    chk("rst_pulses", {13'h0, frame_done, sync_err, timeout}, 16'h0);

    // Scan "1234" with exact latency on the final digit
    fd0 = fd_cnt; se0 = se_cnt;
    drive(AN_POS0, SEG_1, 1'b0, 8);
    drive(AN_POS1, SEG_2, 1'b0, 8);
    drive(AN_POS2, SEG_3, 1'b0, 8);
    DISP = {AN_POS3, SEG_4, 1'b1};
    repeat (5) @(negedge clk);
    chk("lat_early_fd", {15'h0, frame_done}, 16'h0);
    chk("lat_early_fv", {15'h0, frame_valid}, 16'h0);
    @(negedge clk);
    chk("lat_fd", {15'h0, frame_done}, 16'h1);
    chk("lat_digits", digits, 16'h1234);
    repeat (2) @(negedge clk);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("t1_fd_cnt", 16'(fd_cnt - fd0), 16'd1);
    chk("t1_digits", digits, 16'h1234);
    chk("t1_dp", {12'h0, dp}, 16'h0);
    chk("t1_invalid", {12'h0, invalid}, 16'h0);
    chk("t1_fv", {15'h0, frame_valid}, 16'h1);
    chk("t1_sync", 16'(se_cnt - se0), 16'd0);

    // Short ghost patterns between digits must never be accepted
    do_reset();
    fd0 = fd_cnt; se0 = se_cnt;
    drive(AN_POS0, SEG_1, 1'b0, 8);
    drive(AN_POS1, SEG_1, 1'b0, 2);
    drive(AN_POS1, SEG_2, 1'b0, 8);
    drive(AN_POS2, SEG_2, 1'b0, 2);
    drive(AN_POS2, SEG_3, 1'b0, 8);
    drive(AN_POS3, SEG_3, 1'b0, 3);
    drive(AN_POS3, SEG_4, 1'b0, 8);
    drive(AN_POS0, SEG_4, 1'b0, 3);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("t2_digits", digits, 16'h1234);
    chk("t2_fd_cnt", 16'(fd_cnt - fd0), 16'd1);
    chk("t2_sync", 16'(se_cnt - se0), 16'd0);

    // "9", blank with dp, "0", "7" separated by blanking gaps
    fd0 = fd_cnt;
    drive(AN_POS0, SEG_9, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 3);
    drive(AN_POS1, SEG_BLANK, 1'b1, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 3);
    drive(AN_POS2, SEG_0, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 3);
    drive(AN_POS3, SEG_7, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("t3_digits", digits, 16'h9F07);
    chk("t3_dp", {12'h0, dp}, 16'h0004);
    chk("t3_invalid", {12'h0, invalid}, 16'h0);
    chk("t3_fd_cnt", 16'(fd_cnt - fd0), 16'd1);

    // Unrecognised pattern on position 2
    drive(AN_POS0, SEG_3, 1'b0, 8);
    drive(AN_POS1, SEG_1, 1'b0, 8);
    drive(AN_POS2, 7'b1111110, 1'b0, 8);
    drive(AN_POS3, SEG_5, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("t4_digits", digits, 16'h31E5);
    chk("t4_invalid", {12'h0, invalid}, 16'h0002);
    chk("t4_dp", {12'h0, dp}, 16'h0);

    // Skipped position: sync error, previous frame retained
    fd0 = fd_cnt; se0 = se_cnt;
    drive(AN_POS0, SEG_1, 1'b0, 8);
    drive(AN_POS1, SEG_2, 1'b0, 8);
    drive(AN_POS3, SEG_4, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("t5_sync", 16'(se_cnt - se0), 16'd1);
    chk("t5_fd_none", 16'(fd_cnt - fd0), 16'd0);
    chk("t5_keep_digits", digits, 16'h31E5);
    chk("t5_keep_invalid", {12'h0, invalid}, 16'h0002);
    chk("t5_keep_fv", {15'h0, frame_valid}, 16'h1);
    drive(AN_POS0, SEG_5, 1'b0, 8);
    drive(AN_POS1, SEG_6, 1'b0, 8);
    drive(AN_POS2, SEG_7, 1'b0, 8);
    drive(AN_POS3, SEG_8, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("t5_digits", digits, 16'h5678);
    chk("t5_invalid", {12'h0, invalid}, 16'h0);
    chk("t5_fd_cnt", 16'(fd_cnt - fd0), 16'd1);

    // Refresh of position 0 is silent; a restart at position 0 resyncs
    fd0 = fd_cnt; se0 = se_cnt;
    drive(AN_POS0, SEG_7, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 3);
    drive(AN_POS0, SEG_1, 1'b0, 8);
    drive(AN_POS1, SEG_2, 1'b0, 8);
    drive(AN_POS0, SEG_9, 1'b0, 8);
    drive(AN_POS1, SEG_4, 1'b0, 8);
    drive(AN_POS2, SEG_3, 1'b0, 8);
    drive(AN_POS3, SEG_0, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("resync_digits", digits, 16'h9430);
    chk("resync_sync", 16'(se_cnt - se0), 16'd1);
    chk("resync_fd", 16'(fd_cnt - fd0), 16'd1);

    // Timeout on the 64-cycle instance
    do_reset();
    drive(AN_POS0, SEG_4, 1'b0, 8);
    drive(AN_POS1, SEG_3, 1'b0, 8);
    drive(AN_POS2, SEG_2, 1'b0, 8);
    DISP = {AN_POS3, SEG_1, 1'b1};
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done_to;
    end
    chk("to_frame_seen", {15'h0, seen}, 16'h1);
    chk("to_fv_before", {15'h0, frame_valid_to}, 16'h1);
    DISP = 12'hFFF;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      k++;
      seen = timeout_to;
    end
    chk("to_seen", {15'h0, seen}, 16'h1);
    chk("to_latency", 16'(k), 16'd64);
    chk("to_fv_after", {15'h0, frame_valid_to}, 16'h0);
    chk("to_digits_kept", digits_to, 16'h4321);
    @(negedge clk);
    chk("to_one_pulse", {15'h0, timeout_to}, 16'h0);

    // Reset in the middle of a frame
    fd0 = fd_cnt;
    drive(AN_POS0, SEG_8, 1'b0, 8);
    drive(AN_POS1, SEG_8, 1'b1, 8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_digits", digits, 16'hFFFF);
    chk("mid_rst_dp", {12'h0, dp}, 16'h0);
    chk("mid_rst_invalid", {12'h0, invalid}, 16'h0);
    chk("mid_rst_fv", {15'h0, frame_valid}, 16'h0);
    chk("mid_rst_pulses", {13'h0, frame_done, sync_err, timeout}, 16'h0);
    rst_n = 1'b1;
    drive(AN_POS2, SEG_8, 1'b0, 8);
    drive(AN_POS3, SEG_8, 1'b0, 8);
    drive(AN_NONE, SEG_BLANK, 1'b0, 4);
    chk("mid_rst_no_frame", 16'(fd_cnt - fd0), 16'd0);
    chk("mid_rst_digits_after", digits, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
